// File: rtl/udp_port_extract.sv
// Ethernet/IPv4/UDP header stripper: forwards the UDP payload tagged with the destination port on tuser.
// Optional destination-port allow-list: define UDP_PORT_FILTER_EN.
module udp_port_extract #(
  parameter int CHDR_W = 64,
  parameter int USER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [CHDR_W-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [CHDR_W-1:0] o_tdata,
  output logic [USER_W-1:0] o_tuser,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [7:0]  IPV4_VIHL = 8'h45;
  localparam logic [7:0]  IP_UDP    = 8'h11;

  state_t            state;
  logic [2:0]        wcnt;
  logic              ok;
  logic [USER_W-1:0] port_r;

  logic              out_rdy;
  logic              in_hs;
  logic              port_ok;
  logic              word_ok;
  logic              ok_next;
  logic              drop_evt;
  logic [15:0]       hdr_port;

  assign out_rdy  = !o_tvalid || o_tready;
  assign i_tready = (state == PAYLOAD) ? out_rdy : 1'b1;
  assign in_hs    = i_tvalid && i_tready;
  assign hdr_port = i_tdata[47:32];

`ifdef UDP_PORT_FILTER_EN
  assign port_ok = (hdr_port == 16'd49200) || (hdr_port == 16'd49202) ||
                   (hdr_port == 16'd49204);
`else
  assign port_ok = 1'b1;
`endif

  // Each header word contributes its own check; word 0 restarts the verdict.
  always_comb begin
    word_ok = 1'b1;
    case (wcnt)
      3'd2:    word_ok = (i_tdata[47:32] == ETH_IPV4) && (i_tdata[31:24] == IPV4_VIHL);
      3'd3:    word_ok = (i_tdata[23:16] == IP_UDP);
      3'd5:    word_ok = port_ok;
      default: word_ok = 1'b1;
    endcase
    ok_next = ((wcnt == 3'd0) ? 1'b1 : ok) && word_ok;
  end

  // A frame ending inside the header is a drop, except the clean empty-payload case.
  always_comb begin
    drop_evt = 1'b0;
    if (in_hs && i_tlast) begin
      if (state == HDR)       drop_evt = !((wcnt == 3'd5) && ok_next);
      else if (state == DROP) drop_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= HDR;
      wcnt   <= 3'd0;
      ok     <= 1'b0;
      port_r <= '0;
    end else if (clear) begin
      state  <= HDR;
      wcnt   <= 3'd0;
      ok     <= 1'b0;
      port_r <= '0;
    end else begin
      case (state)
        HDR: if (in_hs) begin
          ok <= ok_next;
          if (wcnt == 3'd5) port_r <= hdr_port;
          if (i_tlast) begin
            wcnt <= 3'd0;
          end else if (wcnt == 3'd5) begin
            wcnt  <= 3'd0;
            state <= ok_next ? PAYLOAD : DROP;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        PAYLOAD: if (in_hs && i_tlast) state <= HDR;
        DROP:    if (in_hs && i_tlast) state <= HDR;
        default: state <= HDR;
      endcase
    end
  end

  // Single-stage output register; only PAYLOAD words are loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tlast  <= 1'b0;
    end else if (clear) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tlast  <= 1'b0;
    end else if ((state == PAYLOAD) && in_hs) begin
      o_tvalid <= 1'b1;
      o_tdata  <= i_tdata;
      o_tuser  <= port_r;
      o_tlast  <= i_tlast;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               drop_count <= 16'd0;
    else if (clear)                           drop_count <= 16'd0;
    else if (drop_evt && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

endmodule

// File: doc/udp_port_extract.md
# udp_port_extract

Parses Ethernet/IPv4/UDP frames arriving as 64-bit word streams from the MAC receive path. Strips the 48-byte aligned header and forwards only the UDP payload, tagging every payload word with the UDP destination port on tuser. Sits directly upstream of the control/data stream splitter, which demuxes on that port value. Malformed or non-UDP frames are discarded and counted.

## Interface
- CHDR_W, 64: data width; only 64 is supported.
- USER_W, 16: tuser width; carries the UDP destination port.
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- clear  input  1  synchronous clear; same effect as reset, applied on the clock edge.
- i_tdata  input  CHDR_W  frame word; byte 0 sits in [63:56].
- i_tlast  input  1  last word of frame.
- i_tvalid  input  1  input valid.
- i_tready  output  1  input ready.
- o_tdata  output  CHDR_W  payload word.
- o_tuser  output  USER_W  UDP destination port of the current frame.
- o_tlast  output  1  last payload word.
- o_tvalid  output  1  output valid.
- o_tready  input  1  output ready.
- drop_count  output  16  number of dropped frames; saturates at 0xFFFF.

## Operation
- Input frame layout (byte offsets):
  - 0–5: zero pad.
  - 6–17: MACs.
  - 18–19: ethertype.
  - 20: version/IHL.
  - 29: IP protocol.
  - 40–41: UDP source port.
  - 42–43: UDP destination port.
  - 44–47: UDP length and checksum.
  - 48 onward: payload, starting at word 6.
- Field locations:
  - Word 2: ethertype at [47:32]; version/IHL at [31:24].
  - Word 3: protocol at [23:16].
  - Word 5: destination port at [47:32].
- 3-bit word counter `wcnt`, 0–5, counts header words. It resets to 0 at each frame start.
- The `ok` flag is cleared at frame start. It is set false if any check fails:
  - ethertype != 0x0800,
  - version/IHL != 0x45,
  - protocol != 0x11,
  - `UDP_PORT_FILTER_EN` check (see Configuration).
- States:
  - HDR: i_tready = 1 and header words are consumed. On word 5 the port is latched into `port_r`.
    - If a handshake with i_tlast occurs while wcnt ≤ 5, the frame ends. It counts as a drop unless it ended exactly on word 5 with `ok` set. That case is an empty payload: no output and no drop. Stay in HDR.
    - On word 5 without tlast: go to PAYLOAD if `ok`, otherwise go to DROP.
  - PAYLOAD: i_tready = output-register ready. Each accepted word is loaded into the output register with o_tuser = port_r and o_tlast = i_tlast. Return to HDR on the tlast handshake.
  - DROP: i_tready = 1 and words are discarded. On the tlast handshake, drop_count increments (saturating) and the state returns to HDR.
- Output register: single stage. Ready to load = !o_tvalid | o_tready. o_tvalid is cleared on the handshake unless a new word is loaded in the same cycle.
- Payload words pass through unmodified; trailing partial bytes in the last word pass through as-is.

## Timing
- Reset or clear values:
  - state HDR, wcnt 0, port_r 0.
  - o_tvalid 0, o_tdata 0, o_tuser 0, o_tlast 0.
  - drop_count 0, i_tready 1.
- Latency: input payload word to o_tvalid is 1 cycle.
- Throughput: 1 word/cycle in all states while o_tready = 1.
- Header overhead: 6 input cycles with no output.
- Output stability: o_tdata/o_tuser/o_tlast hold while o_tvalid & !o_tready. o_tvalid never drops without a handshake.
- i_tvalid low mid-frame: state and wcnt hold.
- Frame boundary: the last payload word and the next frame's word 0 may be accepted in consecutive cycles.
- Reset or clear mid-frame: the output register empties immediately and the partial frame is lost. The next accepted word is treated as word 0; upstream must realign to a frame start.
- Counter saturation: drop_count at 0xFFFF stays at 0xFFFF on further drops.

## Configuration
- `UDP_PORT_FILTER_EN` defined: frames whose destination port is not 49200, 49202 or 49204 are dropped and counted.
- `UDP_PORT_FILTER_EN` undefined: any destination port is forwarded.

## Test plan
- Valid frame, port 49200, 4 payload words, o_tready = 1 → 4 output words identical to input words 6–9; o_tuser = 49200; o_tlast on word 4; drop_count = 0.
- Ethertype 0x86DD, 10-word frame → no output; i_tready stays 1; drop_count = 1. Repeat 0x10000 times → drop_count = 0xFFFF.
- Frame with tlast on word 3 → dropped, drop_count + 1. Frame with tlast on word 5 and valid headers → no output, no drop.
- Back-to-back 8-word frames, ports 49202 then 49204, o_tready toggling 1/0 every cycle → no loss or duplication; tuser switches exactly at the frame boundary.
- Async reset asserted during payload word 2 → o_tvalid = 0 immediately; after release, the next valid frame passes correctly.
- Port 5000, valid frame → with `UDP_PORT_FILTER_EN`: dropped, drop_count + 1; without it: forwarded with o_tuser = 5000.
